// File: rtl/update_knn6_knn_insert.sv
`default_nettype none
// ============================================================================
//  Module      : update_knn6_knn_insert
//  Description : Aligns sample sideband with the distance multiplier pipeline
//                and keeps a sorted list of the K smallest distances/labels.
//  Revision    : 1.0 - initial release
// ============================================================================
module update_knn6_knn_insert #(
  parameter int K           = 3,
  parameter int DIST_WIDTH  = 32,
  parameter int LABEL_WIDTH = 4,
  parameter int MUL_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ce,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [LABEL_WIDTH-1:0]     in_label,
  input  logic                       in_last,
  input  logic [DIST_WIDTH-1:0]      mul_dout,
  output logic                       busy,
  output logic                       done,
  output logic [K*DIST_WIDTH-1:0]    knn_dist,
  output logic [K*LABEL_WIDTH-1:0]   knn_label
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [MUL_LATENCY-1:0] r_dl_valid;
  logic [MUL_LATENCY-1:0] r_dl_last;
  logic [LABEL_WIDTH-1:0] r_dl_label [MUL_LATENCY];

  logic                   w_accept;
  logic                   w_insert;
  logic                   w_aligned_valid;
  logic                   w_aligned_last;
  logic [LABEL_WIDTH-1:0] w_aligned_label;

  logic [DIST_WIDTH-1:0]  r_dist      [K];
  logic [LABEL_WIDTH-1:0] r_label     [K];
  logic [DIST_WIDTH-1:0]  w_dist_ins  [K];
  logic [LABEL_WIDTH-1:0] w_label_ins [K];
  logic [K-1:0]           w_lt;

  // A sample offered together with start belongs to the new test digit.
  assign w_accept        = ce & in_valid & ((r_state == ST_RUN) | start);
  assign w_aligned_valid = r_dl_valid[MUL_LATENCY-1];
  assign w_aligned_last  = r_dl_last[MUL_LATENCY-1];
  assign w_aligned_label = r_dl_label[MUL_LATENCY-1];
  assign w_insert        = ce & w_aligned_valid & (r_state == ST_RUN) & ~start;

  // --------------------------------------------------------------------------
  // Sideband delay line, matched to the multiplier register stages
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dl_valid[0] <= 1'b0;
      r_dl_last[0]  <= 1'b0;
      r_dl_label[0] <= '0;
    end else if (ce) begin
      r_dl_valid[0] <= w_accept;
      r_dl_last[0]  <= in_last;
      r_dl_label[0] <= in_label;
    end
  end

  genvar s;
  generate
    for (s = 1; s < MUL_LATENCY; s++) begin : g_dl_stage
      always_ff @(posedge clk) begin
        if (reset) begin
          r_dl_valid[s] <= 1'b0;
          r_dl_last[s]  <= 1'b0;
          r_dl_label[s] <= '0;
        end else if (ce) begin
          r_dl_valid[s] <= r_dl_valid[s-1] & ~start;
          r_dl_last[s]  <= r_dl_last[s-1];
          r_dl_label[s] <= r_dl_label[s-1];
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Sorted list. Displacement uses strict less-than, so the list stays sorted
  // and equal distances keep arrival order; w_lt is therefore monotonic.
  // --------------------------------------------------------------------------
  genvar i;
  generate
    for (i = 0; i < K; i++) begin : g_entry
      assign w_lt[i] = (mul_dout < r_dist[i]);

      if (i == 0) begin : g_head
        assign w_dist_ins[i]  = w_lt[i] ? mul_dout        : r_dist[i];
        assign w_label_ins[i] = w_lt[i] ? w_aligned_label : r_label[i];
      end else begin : g_tail
        assign w_dist_ins[i]  = !w_lt[i]  ? r_dist[i]   :
                                w_lt[i-1] ? r_dist[i-1] : mul_dout;
        assign w_label_ins[i] = !w_lt[i]  ? r_label[i]   :
                                w_lt[i-1] ? r_label[i-1] : w_aligned_label;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_dist[i]  <= '1;
          r_label[i] <= '0;
        end else if (ce) begin
          if (start) begin
            r_dist[i]  <= '1;
            r_label[i] <= '0;
          end else if (w_insert) begin
            r_dist[i]  <= w_dist_ins[i];
            r_label[i] <= w_label_ins[i];
          end
        end
      end

      assign knn_dist[i*DIST_WIDTH +: DIST_WIDTH]    = r_dist[i];
      assign knn_label[i*LABEL_WIDTH +: LABEL_WIDTH] = r_label[i];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (ce) begin
      if (start) begin
        w_next_state = ST_RUN;
      end else begin
        case (r_state)
          ST_IDLE: w_next_state = ST_IDLE;
          ST_RUN:  if (w_insert && w_aligned_last) w_next_state = ST_DONE;
          ST_DONE: w_next_state = ST_IDLE;
          default: w_next_state = ST_IDLE;
        endcase
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_update_knn6_knn_insert.sv
`default_nettype none
// ============================================================================
//  Module      : tb_update_knn6_knn_insert
//  Description : Self-checking bench with a ce-gated multiplier pipeline model
//                and a sorted-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_update_knn6_knn_insert;

  localparam int K  = 3;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int ML = 2;

  typedef logic [DW-1:0] dq_t[$];
  typedef logic [LW-1:0] lq_t[$];

  logic          clk = 1'b0;
  logic          reset, ce, start, in_valid, in_last;
  logic [LW-1:0] in_label;
  logic [DW-1:0] din_dist;
  logic [DW-1:0] mul_dout;
  logic          busy, done;
  logic [K*DW-1:0] knn_dist;
  logic [K*LW-1:0] knn_label;
  logic [DW-1:0] pipe [ML];

  logic [DW-1:0] m_dist  [K];
  logic [LW-1:0] m_label [K];

  int errors = 0;
  int checks = 0;

  update_knn6_knn_insert #(.K(K), .DIST_WIDTH(DW), .LABEL_WIDTH(LW), .MUL_LATENCY(ML)) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .in_valid(in_valid),
    .in_label(in_label), .in_last(in_last), .mul_dout(mul_dout),
    .busy(busy), .done(done), .knn_dist(knn_dist), .knn_label(knn_label)
  );

  always #5 clk = ~clk;

  // Stand-in for the multiplier: ML ce-gated register stages.
  always @(posedge clk) begin
    if (ce) begin
      pipe[0] <= din_dist;
      for (int j = 1; j < ML; j++) pipe[j] <= pipe[j-1];
    end
  end
  assign mul_dout = pipe[ML-1];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_label = '0; din_dist = '0;
  endtask

  task automatic model_clear();
    for (int j = 0; j < K; j++) begin m_dist[j] = '1; m_label[j] = '0; end
  endtask

  task automatic model_insert(input logic [DW-1:0] d, input logic [LW-1:0] l);
    int p;
    p = K;
    for (int j = K - 1; j >= 0; j--) if (d < m_dist[j]) p = j;
    if (p < K) begin
      for (int j = K - 1; j > p; j--) begin m_dist[j] = m_dist[j-1]; m_label[j] = m_label[j-1]; end
      m_dist[p] = d; m_label[p] = l;
    end
  endtask

  task automatic check_list(input string name);
    for (int j = 0; j < K; j++) begin
      checks++;
      if (knn_dist[j*DW +: DW] !== m_dist[j]) begin
        errors++;
        $display("FAIL %s dist[%0d]: got %h expected %h", name, j, knn_dist[j*DW +: DW], m_dist[j]);
      end
      checks++;
      if (knn_label[j*LW +: LW] !== m_label[j]) begin
        errors++;
        $display("FAIL %s label[%0d]: got %0d expected %0d", name, j, knn_label[j*LW +: LW], m_label[j]);
      end
    end
  endtask

  task automatic check_ctrl(input string name, input logic eb, input logic ed);
    checks++;
    if (busy !== eb) begin
      errors++;
      $display("FAIL %s busy: got %b expected %b", name, busy, eb);
    end
    checks++;
    if (done !== ed) begin
      errors++;
      $display("FAIL %s done: got %b expected %b", name, done, ed);
    end
  endtask

  // Starts a test digit, feeds the stream, waits for done and checks the list.
  task automatic run_stream(input string name, input dq_t d, input lq_t l,
                            input bit ce_toggle, input bit check_lat);
    int n;
    model_clear();
    ce = 1'b1; idle_inputs(); start = 1'b1;
    cyc();
    start = 1'b0;
    check_ctrl({name, "_start"}, 1'b1, 1'b0);
    for (int j = 0; j < d.size(); j++) begin
      if (ce_toggle) begin
        ce = 1'b0; in_valid = 1'b1; in_label = 4'hF; din_dist = 32'd0; in_last = 1'b1;
        cyc();
        ce = 1'b1;
      end
      in_valid = 1'b1; in_label = l[j]; din_dist = d[j]; in_last = (j == d.size() - 1);
      cyc();
      model_insert(d[j], l[j]);
    end
    idle_inputs();
    n = 0;
    while (!done && n < 40) begin
      if (ce_toggle) ce = ~ce;
      cyc();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s done_timeout: got done=0 expected done=1 within 40 cycles", name);
    end
    if (check_lat) begin
      checks++;
      if (n != ML) begin
        errors++;
        $display("FAIL %s done_latency: got %0d cycles expected %0d", name, n, ML);
      end
    end
    check_list({name, "_final"});
    if (ce_toggle) begin
      ce = 1'b0;
      cyc(); cyc();
      check_ctrl({name, "_held"}, 1'b0, 1'b1);
    end
    ce = 1'b1;
    cyc();
    check_ctrl({name, "_after"}, 1'b0, 1'b0);
    check_list({name, "_idle"});
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; idle_inputs();
    repeat (3) cyc();
    reset = 1'b0;
    repeat (5) cyc();
    model_clear();
    check_ctrl("reset", 1'b0, 1'b0);
    check_list("reset");
  endtask

  task automatic test_basic();
    run_stream("basic", '{32'd50, 32'd20, 32'd70, 32'd10, 32'd60}, '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5}, 1'b0, 1'b1);
  endtask

  task automatic test_ties();
    run_stream("ties", '{32'd30, 32'd30, 32'd30, 32'd30}, '{4'd1, 4'd2, 4'd3, 4'd4}, 1'b0, 1'b1);
  endtask

  task automatic test_ce_gating();
    run_stream("ce_gate", '{32'd50, 32'd20, 32'd70, 32'd10, 32'd60}, '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5}, 1'b1, 1'b0);
  endtask

  task automatic test_few_allones();
    run_stream("few", '{32'hFFFF_FFFF, 32'd100}, '{4'd5, 4'd6}, 1'b0, 1'b1);
  endtask

  task automatic test_idle_ignore();
    ce = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; in_label = 4'd9; din_dist = 32'd1; in_last = 1'b1;
      cyc();
    end
    idle_inputs();
    repeat (4) cyc();
    check_ctrl("idle_ignore", 1'b0, 1'b0);
    check_list("idle_ignore");
  endtask

  task automatic test_restart();
    model_clear();
    ce = 1'b1; idle_inputs(); start = 1'b1;
    cyc();
    start = 1'b0;
    in_valid = 1'b1; in_label = 4'd1; din_dist = 32'd10; cyc();
    in_valid = 1'b1; in_label = 4'd2; din_dist = 32'd20; cyc();
    idle_inputs(); start = 1'b1;
    cyc();
    start = 1'b0;
    check_ctrl("restart", 1'b1, 1'b0);
    check_list("restart_clear");
    repeat (3) cyc();
    check_ctrl("restart_flush", 1'b1, 1'b0);
    check_list("restart_flush");
    run_stream("restart_new", '{32'd90}, '{4'd7}, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    model_clear();
    ce = 1'b1; idle_inputs(); start = 1'b1;
    cyc();
    start = 1'b0;
    in_valid = 1'b1; in_label = 4'd3; din_dist = 32'd5; in_last = 1'b1;
    cyc();
    idle_inputs();
    cyc();
    reset = 1'b1;
    cyc();
    check_ctrl("reset_mid", 1'b0, 1'b0);
    check_list("reset_mid");
    reset = 1'b0;
    repeat (3) cyc();
    check_ctrl("reset_mid_after", 1'b0, 1'b0);
    check_list("reset_mid_after");
  endtask

  task automatic test_random();
    dq_t d;
    lq_t l;
    int n;
    for (int r = 0; r < 6; r++) begin
      d.delete(); l.delete();
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        if (j > 0 && $urandom_range(0, 3) == 0) d.push_back(d[j-1]);
        else d.push_back(32'($urandom_range(0, 131071)) * 32'($urandom_range(0, 32767)));
        l.push_back(4'($urandom_range(0, 9)));
      end
      run_stream($sformatf("random%0d", r), d, l, r[0], !r[0]);
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; idle_inputs();
    test_reset();
    test_basic();
    test_ties();
    test_ce_gating();
    test_few_allones();
    test_idle_ignore();
    test_restart();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
